// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
package mux4_rr_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // The output stage is either empty or holding one unconsumed word.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot4(input sel_t s);
    logic [N_REQ-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Producer/consumer bundle for mux4_rr_arbiter: four request/data ports in,
// one-hot grant back, one valid/ready output.
interface mux4_rr_arbiter_if #(
  parameter int unsigned Width = 4
);
  import mux4_rr_pkg::*;

  logic [N_REQ-1:0] req;
  logic [Width-1:0] in1;
  logic [Width-1:0] in2;
  logic [Width-1:0] in3;
  logic [Width-1:0] in4;
  logic [N_REQ-1:0] gnt;
  logic [Width-1:0] ou1;
  sel_t             sel;
  logic             out_valid;
  logic             out_ready;

  // Arbiter side.
  modport slave (
    input  req, in1, in2, in3, in4, out_ready,
    output gnt, ou1, sel, out_valid
  );

  // Producers and consumer side.
  modport master (
    output req, in1, in2, in3, in4, out_ready,
    input  gnt, ou1, sel, out_valid
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority encoder: the first set request found when
// scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4) wins.
module rr_pick4
  import mux4_rr_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output logic             any,
  output sel_t             win,
  output logic [N_REQ-1:0] gnt_oh
);

  sel_t idx;

  // Scan from ptr with 2-bit wraparound; only the first hit is kept.
  always_comb begin
    any    = 1'b0;
    win    = ptr;
    idx    = '0;
    gnt_oh = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = sel_t'(ptr + sel_t'(i));
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
    if (any) begin
      gnt_oh = onehot4(win);
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one registered Width-bit output between four
// requesters, with a valid/ready handshake toward the consumer.
module mux4_rr_arbiter
  import mux4_rr_pkg::*;
#(
  parameter int unsigned Width = 4
) (
  input logic                clk,
  input logic                rst,
  mux4_rr_arbiter_if.slave   bus
);

  state_t           state_q;
  state_t           state_d;
  sel_t             ptr_q;
  sel_t             sel_q;
  logic [Width-1:0] ou1_q;
  logic [Width-1:0] word;
  logic             any;
  sel_t             win;
  logic [N_REQ-1:0] gnt_oh;
  logic             load;
  logic             take;

  rr_pick4 u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .any    (any),
    .win    (win),
    .gnt_oh (gnt_oh)
  );

  // State register: out_valid is the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Load/capture decision and next state; a stalled FULL stage holds.
  // take is gated by rst so no grant is shown while reset is asserted.
  always_comb begin
    state_d = state_q;
    load    = (state_q == EMPTY) || bus.out_ready;
    take    = load && any && !rst;
    if (load) begin
      state_d = any ? FULL : EMPTY;
    end
  end

  // 4:1 data select driven only by the registered pointer and requests.
  always_comb begin
    word = '0;
    case (win)
      2'd0:    word = bus.in1;
      2'd1:    word = bus.in2;
      2'd2:    word = bus.in3;
      default: word = bus.in4;
    endcase
  end

  // Output word, source index and rotating pointer update on capture only.
  always_ff @(posedge clk) begin
    if (rst) begin
      ou1_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
    end else if (take) begin
      ou1_q <= word;
      sel_q <= win;
      ptr_q <= sel_t'(win + 2'd1);
    end
  end

  assign bus.gnt       = take ? gnt_oh : '0;
  assign bus.ou1       = ou1_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = (state_q == FULL);

endmodule
